instruction_fetch_unit: RTL and testbench



---
 rtl/instruction_fetch_unit_if.sv | 31 +++
 rtl/instruction_fetch_unit.sv | 138 +++++++++++++
 tb/tb_instruction_fetch_unit.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/instruction_fetch_unit_if.sv
// Fetch-unit bus bundle: imem request/response, redirect, and decode handoff.
interface instruction_fetch_unit_if;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_inst;
    logic [31:0] id_pc;
    logic [31:0] id_pc_plus4;

    // Fetch-unit side
    modport master (
        output imem_req_valid, imem_req_addr,
        output id_valid, id_inst, id_pc, id_pc_plus4,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
        input  redirect_valid, redirect_pc, id_ready
    );

    // Memory / decode / branch-resolution side
    modport slave (
        input  imem_req_valid, imem_req_addr,
        input  id_valid, id_inst, id_pc, id_pc_plus4,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data,
        output redirect_valid, redirect_pc, id_ready
    );
endinterface

// File: rtl/instruction_fetch_unit.sv
// RV32I fetch stage: owns the PC, single outstanding imem request,
// small {pc, inst} buffer toward decode, redirect flush.
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned BUF_DEPTH = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    instruction_fetch_unit_if.master  io_bus
);
    localparam int unsigned PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(BUF_DEPTH + 1);
    localparam logic [31:0] NOP   = 32'h0000_0013;

    localparam logic [1:0] S_ISSUE = 2'd0;
    localparam logic [1:0] S_WAIT  = 2'd1;
    localparam logic [1:0] S_DROP  = 2'd2;

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic [31:0]       r_pc;
    logic [31:0]       r_req_pc;
    logic [31:0]       r_buf_pc   [BUF_DEPTH];
    logic [31:0]       r_buf_inst [BUF_DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;

    logic              w_req_valid;
    logic              w_accept;
    logic              w_push;
    logic              w_pop;
    logic              w_head_valid;
    logic              w_redirect;
    logic [31:0]       w_redirect_pc;
    logic [31:0]       w_id_pc;

    assign w_redirect    = io_bus.redirect_valid;
    assign w_redirect_pc = io_bus.redirect_pc & ~32'h0000_0003;
    assign w_head_valid  = (r_count != '0);

    // Next state plus request/push/pop decode; redirect does not gate the request
    always_comb begin
        w_state_nxt = r_state;
        w_req_valid = 1'b0;
        w_accept    = 1'b0;
        w_push      = 1'b0;
        w_pop       = w_head_valid && io_bus.id_ready && !w_redirect;
        case (r_state)
            S_ISSUE: begin
                w_req_valid = !rst && (r_count < CNT_W'(BUF_DEPTH));
                w_accept    = w_req_valid && io_bus.imem_req_ready;
                if (w_accept) begin
                    w_state_nxt = w_redirect ? S_DROP : S_WAIT;
                end
            end
            S_WAIT: begin
                if (io_bus.imem_rsp_valid) begin
                    w_push      = !w_redirect;
                    w_state_nxt = S_ISSUE;
                end else if (w_redirect) begin
                    w_state_nxt = S_DROP;
                end
            end
            S_DROP: begin
                if (io_bus.imem_rsp_valid) begin
                    w_state_nxt = S_ISSUE;
                end
            end
            default: w_state_nxt = S_ISSUE;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_ISSUE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // PC, outstanding-request PC, buffer pointers and occupancy
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc     <= RESET_PC;
            r_req_pc <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (w_redirect) begin
            r_pc     <= w_redirect_pc;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_accept) begin
                r_req_pc <= r_pc;
                r_pc     <= r_pc + 32'd4;
            end
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Buffer storage; contents only matter while counted as occupied
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_buf_pc[r_wr_ptr]   <= r_req_pc;
            r_buf_inst[r_wr_ptr] <= io_bus.imem_rsp_data;
        end
    end

    // A response can never land in a full buffer
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(w_push && (r_count == CNT_W'(BUF_DEPTH))));
        end
    end

    assign w_id_pc = w_head_valid ? r_buf_pc[r_rd_ptr] : 32'h0000_0000;

    assign io_bus.imem_req_valid = w_req_valid;
    assign io_bus.imem_req_addr  = r_pc;
    assign io_bus.id_valid       = w_head_valid;
    assign io_bus.id_inst        = w_head_valid ? r_buf_inst[r_rd_ptr] : NOP;
    assign io_bus.id_pc          = w_id_pc;
    assign io_bus.id_pc_plus4    = w_id_pc + 32'd4;
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit: per-cycle vector table for the
// basic fetch flow, then hand sequences for stall, redirect and reset cases.
module tb_instruction_fetch_unit;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rst_b = 1'b1;

    always #5 clk = ~clk;

    instruction_fetch_unit_if a_if ();
    instruction_fetch_unit_if b_if ();

    instruction_fetch_unit #(.RESET_PC(32'h0000_0000), .BUF_DEPTH(2)) dut_a (
        .clk(clk), .rst(rst), .io_bus(a_if.master)
    );
    instruction_fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .BUF_DEPTH(2)) dut_b (
        .clk(clk), .rst(rst_b), .io_bus(b_if.master)
    );

    // Memory model for dut_a: manual drive or auto reply one cycle after accept
    logic        mem_auto   = 1'b0;
    logic        man_valid  = 1'b0;
    logic [31:0] man_data   = '0;
    logic        auto_valid = 1'b0;
    logic [31:0] auto_data  = '0;

    always @(posedge clk) begin
        auto_valid <= mem_auto && a_if.imem_req_valid && a_if.imem_req_ready;
        auto_data  <= 32'hAAAA_0000 + a_if.imem_req_addr;
    end
    assign a_if.imem_rsp_valid = mem_auto ? auto_valid : man_valid;
    assign a_if.imem_rsp_data  = mem_auto ? auto_data  : man_data;

    // dut_b: free-running wrap test, always-ready memory and decode
    logic        b_rsp_valid = 1'b0;
    logic [31:0] b_rsp_data  = '0;
    always @(posedge clk) begin
        b_rsp_valid <= b_if.imem_req_valid && b_if.imem_req_ready;
        b_rsp_data  <= 32'hAAAA_0000 + b_if.imem_req_addr;
    end
    assign b_if.imem_req_ready = 1'b1;
    assign b_if.imem_rsp_valid = b_rsp_valid;
    assign b_if.imem_rsp_data  = b_rsp_data;
    assign b_if.redirect_valid = 1'b0;
    assign b_if.redirect_pc    = 32'h0;
    assign b_if.id_ready       = 1'b1;

    initial begin
        repeat (3) @(negedge clk);
        rst_b = 1'b0;
    end

    logic [31:0] b_req_addr [3];
    logic [31:0] b_pc [3];
    logic [31:0] b_inst [3];
    logic [31:0] b_p4 [3];
    int nb_req = 0;
    int nb_pop = 0;
    int bad_seen = 0;

    // Observers sample one time unit after the falling edge
    always @(negedge clk) begin
        #1;
        if (!rst_b && b_if.imem_req_valid && nb_req < 3) begin
            b_req_addr[nb_req] = b_if.imem_req_addr;
            nb_req++;
        end
        if (!rst_b && b_if.id_valid && nb_pop < 3) begin
            b_pc[nb_pop]   = b_if.id_pc;
            b_inst[nb_pop] = b_if.id_inst;
            b_p4[nb_pop]   = b_if.id_pc_plus4;
            nb_pop++;
        end
        if (a_if.id_valid && a_if.id_inst == 32'hDEAD_BEEF) bad_seen++;
    end

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic expect_req(input string tag, input logic v, input logic [31:0] addr);
        check({tag, " req_valid"}, 32'(a_if.imem_req_valid), 32'(v));
        if (v) check({tag, " req_addr"}, a_if.imem_req_addr, addr);
    endtask

    task automatic expect_id(input string tag, input logic v, input logic [31:0] inst,
                             input logic [31:0] pc);
        check({tag, " id_valid"}, 32'(a_if.id_valid), 32'(v));
        check({tag, " id_inst"}, a_if.id_inst, inst);
        check({tag, " id_pc"}, a_if.id_pc, pc);
        check({tag, " id_pc_plus4"}, a_if.id_pc_plus4, pc + 32'd4);
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    typedef struct {
        logic        rst;
        logic        req_ready;
        logic        rsp_valid;
        logic [31:0] rsp_data;
        logic        id_ready;
        logic        e_req_valid;
        logic [31:0] e_req_addr;
        logic        e_id_valid;
        logic [31:0] e_id_inst;
        logic [31:0] e_id_pc;
    } vec_t;

    vec_t vec [9];

    initial begin
        a_if.imem_req_ready = 1'b1;
        a_if.redirect_valid = 1'b0;
        a_if.redirect_pc    = 32'h0;
        a_if.id_ready       = 1'b1;

        // Basic flow: 1-cycle memory, decode always ready
        vec[0] = '{1'b1, 1'b1, 1'b0, 32'h0,         1'b1, 1'b0, 32'h0, 1'b0, NOP,          32'h0};
        vec[1] = '{1'b0, 1'b1, 1'b0, 32'h0,         1'b1, 1'b1, 32'h0, 1'b0, NOP,          32'h0};
        vec[2] = '{1'b0, 1'b1, 1'b1, 32'hAAAA_0000, 1'b1, 1'b0, 32'h4, 1'b0, NOP,          32'h0};
        vec[3] = '{1'b0, 1'b1, 1'b0, 32'h0,         1'b1, 1'b1, 32'h4, 1'b1, 32'hAAAA_0000, 32'h0};
        vec[4] = '{1'b0, 1'b1, 1'b1, 32'hAAAA_0004, 1'b1, 1'b0, 32'h8, 1'b0, NOP,          32'h0};
        vec[5] = '{1'b0, 1'b1, 1'b0, 32'h0,         1'b1, 1'b1, 32'h8, 1'b1, 32'hAAAA_0004, 32'h4};
        vec[6] = '{1'b0, 1'b1, 1'b1, 32'hAAAA_0008, 1'b1, 1'b0, 32'hC, 1'b0, NOP,          32'h0};
        vec[7] = '{1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 32'hC, 1'b1, 32'hAAAA_0008, 32'h8};
        vec[8] = '{1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 32'hC, 1'b0, NOP,          32'h0};

        for (int i = 0; i < 9; i++) begin
            step();
            rst = vec[i].rst;
            a_if.imem_req_ready = vec[i].req_ready;
            man_valid = vec[i].rsp_valid;
            man_data  = vec[i].rsp_data;
            a_if.id_ready = vec[i].id_ready;
            #1;
            check($sformatf("vec%0d req_valid", i), 32'(a_if.imem_req_valid), 32'(vec[i].e_req_valid));
            check($sformatf("vec%0d req_addr", i), a_if.imem_req_addr, vec[i].e_req_addr);
            check($sformatf("vec%0d id_valid", i), 32'(a_if.id_valid), 32'(vec[i].e_id_valid));
            check($sformatf("vec%0d id_inst", i), a_if.id_inst, vec[i].e_id_inst);
            check($sformatf("vec%0d id_pc", i), a_if.id_pc, vec[i].e_id_pc);
            check($sformatf("vec%0d id_pc_plus4", i), a_if.id_pc_plus4, vec[i].e_id_pc + 32'd4);
        end

        // Decode stall: buffer fills to two entries, then requests stop
        step(); mem_auto = 1'b1; a_if.imem_req_ready = 1'b1; a_if.id_ready = 1'b0; #1;
        expect_req("stall start", 1'b1, 32'hC);
        repeat (10) step();
        #1;
        expect_req("stall full", 1'b0, 32'h0);
        expect_id("stall head", 1'b1, 32'hAAAA_000C, 32'hC);
        a_if.id_ready = 1'b1;
        step(); #1;
        expect_id("drain 2nd", 1'b1, 32'hAAAA_0010, 32'h10);
        expect_req("drain refill", 1'b1, 32'h14);
        step(); #1;
        check("drain empty id_valid", 32'(a_if.id_valid), 32'h0);
        step(); a_if.imem_req_ready = 1'b0; #1;
        expect_id("drain 3rd", 1'b1, 32'hAAAA_0014, 32'h14);

        // Redirect while waiting; stale response three cycles later
        step(); mem_auto = 1'b0; a_if.imem_req_ready = 1'b1; #1;
        expect_req("pre-redir", 1'b1, 32'h18);
        expect_id("pre-redir", 1'b0, NOP, 32'h0);
        step(); a_if.imem_req_ready = 1'b0;
        a_if.redirect_valid = 1'b1; a_if.redirect_pc = 32'h0000_0102; #1;
        check("wait req_valid", 32'(a_if.imem_req_valid), 32'h0);
        step(); a_if.redirect_valid = 1'b0; #1;
        check("drop1 req_valid", 32'(a_if.imem_req_valid), 32'h0);
        check("drop1 id_valid", 32'(a_if.id_valid), 32'h0);
        step(); #1;
        check("drop2 req_valid", 32'(a_if.imem_req_valid), 32'h0);
        step(); man_valid = 1'b1; man_data = 32'hDEAD_BEEF; #1;
        check("drop3 req_valid", 32'(a_if.imem_req_valid), 32'h0);
        step(); man_valid = 1'b0; a_if.imem_req_ready = 1'b1; #1;
        expect_req("redir target", 1'b1, 32'h0000_0100);
        expect_id("after stale", 1'b0, NOP, 32'h0);
        step(); a_if.imem_req_ready = 1'b0; man_valid = 1'b1; man_data = 32'hBBBB_0100; #1;
        step(); man_valid = 1'b0; #1;
        expect_id("redir first", 1'b1, 32'hBBBB_0100, 32'h100);

        // Redirect coincident with a response: straight back to issue
        step(); a_if.imem_req_ready = 1'b1; #1;
        step(); a_if.imem_req_ready = 1'b0; man_valid = 1'b1; man_data = 32'hDEAD_BEEF;
        a_if.redirect_valid = 1'b1; a_if.redirect_pc = 32'h0000_0200; #1;
        step(); man_valid = 1'b0; a_if.redirect_valid = 1'b0; a_if.imem_req_ready = 1'b1; #1;
        expect_req("rsp+redir", 1'b1, 32'h200);
        check("rsp+redir id_valid", 32'(a_if.id_valid), 32'h0);
        step(); a_if.imem_req_ready = 1'b0; man_valid = 1'b1; man_data = 32'hC0DE_0200; #1;
        step(); man_valid = 1'b0; #1;
        expect_id("rsp+redir first", 1'b1, 32'hC0DE_0200, 32'h200);

        // Redirect coincident with a request accept: its response is dropped
        step(); a_if.imem_req_ready = 1'b1;
        a_if.redirect_valid = 1'b1; a_if.redirect_pc = 32'h0000_0300; #1;
        expect_req("acc+redir", 1'b1, 32'h204);
        step(); a_if.redirect_valid = 1'b0; a_if.imem_req_ready = 1'b0;
        man_valid = 1'b1; man_data = 32'hDEAD_BEEF; #1;
        check("acc+redir drop req_valid", 32'(a_if.imem_req_valid), 32'h0);
        step(); man_valid = 1'b0; a_if.imem_req_ready = 1'b1; #1;
        expect_req("acc+redir target", 1'b1, 32'h300);
        check("acc+redir id_valid", 32'(a_if.id_valid), 32'h0);
        step(); a_if.imem_req_ready = 1'b0; man_valid = 1'b1; man_data = 32'hC0DE_0300; #1;
        step(); man_valid = 1'b0; #1;
        expect_id("acc+redir first", 1'b1, 32'hC0DE_0300, 32'h300);

        // Redirect flushes a full buffer and ignores the same-cycle pop
        step(); mem_auto = 1'b1; a_if.imem_req_ready = 1'b1; a_if.id_ready = 1'b0; #1;
        repeat (6) step();
        #1;
        expect_id("full before flush", 1'b1, 32'hAAAA_0304, 32'h304);
        check("full req_valid", 32'(a_if.imem_req_valid), 32'h0);
        a_if.redirect_valid = 1'b1; a_if.redirect_pc = 32'h0000_0400; a_if.id_ready = 1'b1;
        step(); a_if.redirect_valid = 1'b0; a_if.id_ready = 1'b0; #1;
        expect_id("flushed", 1'b0, NOP, 32'h0);
        expect_req("flushed", 1'b1, 32'h400);
        step(); #1;
        check("refetch wait id_valid", 32'(a_if.id_valid), 32'h0);
        step(); mem_auto = 1'b0; #1;
        expect_id("refetch head", 1'b1, 32'hAAAA_0400, 32'h400);

        // Reset with one entry buffered and a request outstanding
        step(); rst = 1'b1; a_if.imem_req_ready = 1'b0; #1;
        check("in-reset req_valid", 32'(a_if.imem_req_valid), 32'h0);
        step(); rst = 1'b0; man_valid = 1'b1; man_data = 32'hDEAD_BEEF; #1;
        expect_id("post-reset", 1'b0, NOP, 32'h0);
        expect_req("post-reset", 1'b1, 32'h0);
        step(); man_valid = 1'b0; a_if.imem_req_ready = 1'b1; #1;
        expect_id("late rsp ignored", 1'b0, NOP, 32'h0);
        step(); a_if.imem_req_ready = 1'b0; man_valid = 1'b1; man_data = 32'h1111_0000; #1;
        step(); man_valid = 1'b0; a_if.id_ready = 1'b1; #1;
        expect_id("restart", 1'b1, 32'h1111_0000, 32'h0);

        check("stale data seen on id_inst", 32'(bad_seen), 32'h0);

        // Wrap-around of the fetch PC from a high reset address
        check("wrap req count", 32'(nb_req), 32'd3);
        check("wrap pop count", 32'(nb_pop), 32'd3);
        check("wrap req0", b_req_addr[0], 32'hFFFF_FFF8);
        check("wrap req1", b_req_addr[1], 32'hFFFF_FFFC);
        check("wrap req2", b_req_addr[2], 32'h0000_0000);
        check("wrap pc0", b_pc[0], 32'hFFFF_FFF8);
        check("wrap inst0", b_inst[0], 32'hAAA9_FFF8);
        check("wrap pc1", b_pc[1], 32'hFFFF_FFFC);
        check("wrap inst1", b_inst[1], 32'hAAA9_FFFC);
        check("wrap p4_1", b_p4[1], 32'h0000_0000);
        check("wrap pc2", b_pc[2], 32'h0000_0000);
        check("wrap inst2", b_inst[2], 32'hAAAA_0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
